yarvi_wb: RTL and testbench
===========================

# yarvi_wb

Writeback/commit stage directly downstream of the memory (load-store) stage. Consumes the ME outputs (`me_valid`, `me_pc`, `me_wb_rd`, `me_wb_val`, misaligned/load-hit-store/timer flags) and issues one registered register-file write per retired instruction. Turns ME events into a pipeline restart: trap to `MTVEC` or replay of the load. Squashes wrong-path instructions for a fixed drain window and keeps `mepc`/`mcause`/`mtval`/`minstret`.

## Interface

Parameters:
- `MTVEC`, 32'h80000010, trap target PC
- `FLUSH_CYCLES`, 2, cycles of ME output ignored after a restart (pipeline depth between fetch redirect and ME); legal range 1..7

Ports:
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low; all state cleared while low
- `me_valid`  in  1  ME result is a valid retiring instruction
- `me_pc`  in  32  PC of ME instruction
- `me_wb_rd`  in  5  destination register (0 = none)
- `me_wb_val`  in  32  result value
- `me_exc_misaligned`  in  1  misaligned access (arrives with `me_valid`=0)
- `me_exc_store`  in  1  qualifies misaligned: 1 = store, 0 = load
- `me_exc_mtval`  in  32  faulting address
- `me_load_hit_store`  in  1  load must be replayed (arrives with `me_valid`=0)
- `me_timer_interrupt`  in  1  timer pending (level)
- `mie_set`  in  1  pulse: enable interrupts (mret / CSR write)
- `rf_we`  out  1  register-file write enable
- `rf_waddr`  out  5  write address
- `rf_wdata`  out  32  write data
- `restart`  out  1  one-cycle redirect pulse
- `restart_pc`  out  32  redirect target
- `mepc`, `mcause`, `mtval`  out  32 each  trap CSRs
- `minstret`  out  64  retired-instruction count
- `flushing`  out  1  state is FLUSH

## Operation

- States: RUN, FLUSH. A 3-bit drain counter is used in FLUSH.
- In RUN, evaluate one event per cycle. Priority: misaligned > load_hit_store > interrupt > retire.
  - Misaligned: `mepc`←`me_pc`, `mcause`←6 if `me_exc_store` else 4, `mtval`←`me_exc_mtval`, `intr_en`←0, restart to `MTVEC`.
  - Load-hit-store: restart to `me_pc` (replay). CSRs unchanged. No retire.
  - Interrupt: requires `me_valid` & `me_timer_interrupt` & `intr_en`. The instruction is squashed: no write, no retire. `mepc`←`me_pc`, `mcause`←32'h80000007, `mtval`←0, `intr_en`←0, restart to `MTVEC`.
  - Retire: `me_valid` with no event. `rf_we`←(`me_wb_rd`≠0), `rf_waddr`←`me_wb_rd`, `rf_wdata`←`me_wb_val`, `minstret`+1. A write to x0 still retires.
- Any restart: `restart`←1, `restart_pc` set, state→FLUSH, counter←`FLUSH_CYCLES`-1.
- In FLUSH, all ME inputs are ignored: no writes, no retire, no events. The counter decrements each cycle; at 0 the state goes to RUN.
- `intr_en`: reset 0. `mie_set` sets it to 1 in either state. A trap in the same cycle as `mie_set` wins and clears it.
- `minstret` wraps from 2^64-1 to 0.

## Timing

- All outputs are registered. Latency is one cycle from ME inputs to `rf_*`/`restart`/CSR update.
- Event sampled in cycle N:
  - `restart`=1 in N+1 only.
  - `flushing`=1 in N+1 .. N+`FLUSH_CYCLES`.
  - Inputs are honoured again in cycle N+`FLUSH_CYCLES`+1 (the cycle after `flushing` falls).
- `rf_we` is a one-cycle pulse per retire. Back-to-back retires give one write per cycle.
- Reset (low, asynchronous, any state including mid-FLUSH):
  - State=RUN, counter=0.
  - `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0.
  - `restart`=0, `restart_pc`=0.
  - `mepc`=`mcause`=`mtval`=0, `minstret`=0.
  - `intr_en`=0, `flushing`=0.
- After reset deasserts, inputs are honoured from the first rising edge.

## Test plan

- Retire stream: 4 back-to-back valid instructions, rd=1,2,0,3, vals 10,20,30,40 → `rf_we` on cycles 1,2,4 with matching addr/data, none on cycle 3; `minstret`=4.
- Misaligned load: `me_exc_misaligned`=1, `me_exc_store`=0, pc 0x80000100, mtval 0x80000203 → next cycle `restart`=1, `restart_pc`=0x80000010, `mepc`=0x80000100, `mcause`=4, `mtval`=0x80000203. Two valid instructions presented during FLUSH produce no writes and `minstret` does not increment.
- Load-hit-store at pc 0x80000040 → `restart_pc`=0x80000040, CSRs unchanged, no write. After 2 FLUSH cycles, the replayed valid load (rd=5, val 0xDEAD) writes.
- Timer interrupt: with `intr_en`=0 the instruction retires. Pulse `mie_set`, then valid pc 0x80000080 with timer pending → squashed, `mcause`=0x80000007, `mepc`=0x80000080, restart to `MTVEC`. A second pending timer after FLUSH does not trap.
- Simultaneous misaligned + timer (`intr_en`=1) → `mcause`=4 or 6, not 0x80000007.
- Reset asserted low during FLUSH cycle 1 → all outputs 0 immediately (asynchronously). After release, a valid instruction retires on the first edge.

Source files
------------

// File: rtl/yarvi_wb.sv
// yarvi_wb: writeback/commit stage after ME.
// Retires into the RF, raises traps/replays, drains wrong-path work.
module yarvi_wb #(
  parameter logic [31:0] MTVEC        = 32'h8000_0010,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        me_valid,
  input  logic [31:0] me_pc,
  input  logic [4:0]  me_wb_rd,
  input  logic [31:0] me_wb_val,
  input  logic        me_exc_misaligned,
  input  logic        me_exc_store,
  input  logic [31:0] me_exc_mtval,
  input  logic        me_load_hit_store,
  input  logic        me_timer_interrupt,
  input  logic        mie_set,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        restart,
  output logic [31:0] restart_pc,
  output logic [31:0] mepc,
  output logic [31:0] mcause,
  output logic [31:0] mtval,
  output logic [63:0] minstret,
  output logic        flushing
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        intr_en_q, intr_en_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic        restart_q, restart_d;
  logic [31:0] restart_pc_q, restart_pc_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;
  logic [63:0] minstret_q, minstret_d;

  logic ev_mis, ev_lhs, ev_irq, ev_ret;

  // One-hot event selection in priority order
  always_comb begin
    ev_mis = me_exc_misaligned;
    ev_lhs = me_load_hit_store & ~ev_mis;
    ev_irq = me_valid & me_timer_interrupt & intr_en_q
           & ~ev_mis & ~me_load_hit_store;
    ev_ret = me_valid & ~ev_mis & ~me_load_hit_store
           & ~(me_timer_interrupt & intr_en_q);
  end

  // Next-state, commit and CSR update
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    intr_en_d    = intr_en_q | mie_set;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    restart_d    = 1'b0;
    restart_pc_d = restart_pc_q;
    mepc_d       = mepc_q;
    mcause_d     = mcause_q;
    mtval_d      = mtval_q;
    minstret_d   = minstret_q;
    unique case (state_q)
      RUN: begin
        unique case (1'b1)
          ev_mis: begin
            mepc_d       = me_pc;
            mcause_d     = me_exc_store ? 32'd6 : 32'd4;
            mtval_d      = me_exc_mtval;
            intr_en_d    = 1'b0;
            restart_d    = 1'b1;
            restart_pc_d = MTVEC;
            state_d      = FLUSH;
            cnt_d        = FLUSH_INIT;
          end
          ev_lhs: begin
            restart_d    = 1'b1;
            restart_pc_d = me_pc;
            state_d      = FLUSH;
            cnt_d        = FLUSH_INIT;
          end
          ev_irq: begin
            mepc_d       = me_pc;
            mcause_d     = 32'h8000_0007;
            mtval_d      = 32'd0;
            intr_en_d    = 1'b0;
            restart_d    = 1'b1;
            restart_pc_d = MTVEC;
            state_d      = FLUSH;
            cnt_d        = FLUSH_INIT;
          end
          ev_ret: begin
            rf_we_d    = me_wb_rd != 5'd0;
            rf_waddr_d = me_wb_rd;
            rf_wdata_d = me_wb_val;
            minstret_d = minstret_q + 64'd1;
          end
          default: ;
        endcase
      end
      FLUSH: begin
        if (cnt_q == 3'd0) state_d = RUN;
        else cnt_d = cnt_q - 3'd1;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= RUN;
      cnt_q        <= 3'd0;
      intr_en_q    <= 1'b0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= 5'd0;
      rf_wdata_q   <= 32'd0;
      restart_q    <= 1'b0;
      restart_pc_q <= 32'd0;
      mepc_q       <= 32'd0;
      mcause_q     <= 32'd0;
      mtval_q      <= 32'd0;
      minstret_q   <= 64'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      intr_en_q    <= intr_en_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      restart_q    <= restart_d;
      restart_pc_q <= restart_pc_d;
      mepc_q       <= mepc_d;
      mcause_q     <= mcause_d;
      mtval_q      <= mtval_d;
      minstret_q   <= minstret_d;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign restart    = restart_q;
  assign restart_pc = restart_pc_q;
  assign mepc       = mepc_q;
  assign mcause     = mcause_q;
  assign mtval      = mtval_q;
  assign minstret   = minstret_q;
  assign flushing   = state_q == FLUSH;

endmodule

// File: tb/tb_yarvi_wb.sv
// tb_yarvi_wb: directed bench for the writeback stage.
// Inputs change 1ns after the rising edge; outputs sampled there too.
module tb_yarvi_wb;

  logic        clock = 1'b0;
  logic        reset;
  logic        me_valid;
  logic [31:0] me_pc;
  logic [4:0]  me_wb_rd;
  logic [31:0] me_wb_val;
  logic        me_exc_misaligned;
  logic        me_exc_store;
  logic [31:0] me_exc_mtval;
  logic        me_load_hit_store;
  logic        me_timer_interrupt;
  logic        mie_set;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        restart;
  logic [31:0] restart_pc;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] mtval;
  logic [63:0] minstret;
  logic        flushing;

  int n_chk  = 0;
  int n_fail = 0;

  yarvi_wb dut (
    .clock              (clock),
    .reset              (reset),
    .me_valid           (me_valid),
    .me_pc              (me_pc),
    .me_wb_rd           (me_wb_rd),
    .me_wb_val          (me_wb_val),
    .me_exc_misaligned  (me_exc_misaligned),
    .me_exc_store       (me_exc_store),
    .me_exc_mtval       (me_exc_mtval),
    .me_load_hit_store  (me_load_hit_store),
    .me_timer_interrupt (me_timer_interrupt),
    .mie_set            (mie_set),
    .rf_we              (rf_we),
    .rf_waddr           (rf_waddr),
    .rf_wdata           (rf_wdata),
    .restart            (restart),
    .restart_pc         (restart_pc),
    .mepc               (mepc),
    .mcause             (mcause),
    .mtval              (mtval),
    .minstret           (minstret),
    .flushing           (flushing)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    me_valid           = 1'b0;
    me_pc              = 32'd0;
    me_wb_rd           = 5'd0;
    me_wb_val          = 32'd0;
    me_exc_misaligned  = 1'b0;
    me_exc_store       = 1'b0;
    me_exc_mtval       = 32'd0;
    me_load_hit_store  = 1'b0;
    me_timer_interrupt = 1'b0;
    mie_set            = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic check_zero(input string p);
    check({p, ".rf_we"}, 64'(rf_we), 64'd0);
    check({p, ".rf_waddr"}, 64'(rf_waddr), 64'd0);
    check({p, ".rf_wdata"}, 64'(rf_wdata), 64'd0);
    check({p, ".restart"}, 64'(restart), 64'd0);
    check({p, ".restart_pc"}, 64'(restart_pc), 64'd0);
    check({p, ".mepc"}, 64'(mepc), 64'd0);
    check({p, ".mcause"}, 64'(mcause), 64'd0);
    check({p, ".mtval"}, 64'(mtval), 64'd0);
    check({p, ".minstret"}, minstret, 64'd0);
    check({p, ".flushing"}, 64'(flushing), 64'd0);
  endtask

  task automatic retire(input logic [31:0] pc,
                        input logic [4:0] rd,
                        input logic [31:0] val);
    idle();
    me_valid  = 1'b1;
    me_pc     = pc;
    me_wb_rd  = rd;
    me_wb_val = val;
  endtask

  logic [4:0]  rds [4] = '{5'd1, 5'd2, 5'd0, 5'd3};
  logic [31:0] vals[4] = '{32'd10, 32'd20, 32'd30, 32'd40};

  initial begin
    reset = 1'b0;
    idle();
    #3;
    check_zero("rst0");
    #9;
    reset = 1'b1;

    // back-to-back retires, x0 write suppressed
    for (int i = 0; i < 4; i++) begin
      retire(32'h8000_0000 + 32'(4 * i), rds[i], vals[i]);
      cyc();
      check($sformatf("ret%0d.we", i), 64'(rf_we),
            64'(rds[i] != 5'd0));
      if (rds[i] != 5'd0) begin
        check($sformatf("ret%0d.addr", i), 64'(rf_waddr), 64'(rds[i]));
        check($sformatf("ret%0d.data", i), 64'(rf_wdata), 64'(vals[i]));
      end
    end
    check("ret.minstret", minstret, 64'd4);

    // misaligned load trap
    idle();
    me_exc_misaligned = 1'b1;
    me_pc             = 32'h8000_0100;
    me_exc_mtval      = 32'h8000_0203;
    cyc();
    check("mis.restart", 64'(restart), 64'd1);
    check("mis.rpc", 64'(restart_pc), 64'h8000_0010);
    check("mis.mepc", 64'(mepc), 64'h8000_0100);
    check("mis.mcause", 64'(mcause), 64'd4);
    check("mis.mtval", 64'(mtval), 64'h8000_0203);
    check("mis.flushing", 64'(flushing), 64'd1);
    check("mis.we", 64'(rf_we), 64'd0);
    retire(32'h8000_0104, 5'd7, 32'd1);
    cyc();
    check("fl1.restart", 64'(restart), 64'd0);
    check("fl1.flushing", 64'(flushing), 64'd1);
    check("fl1.we", 64'(rf_we), 64'd0);
    retire(32'h8000_0108, 5'd7, 32'd2);
    cyc();
    check("fl2.flushing", 64'(flushing), 64'd0);
    check("fl2.we", 64'(rf_we), 64'd0);
    check("fl2.minstret", minstret, 64'd4);

    // load-hit-store replay
    idle();
    me_load_hit_store = 1'b1;
    me_pc             = 32'h8000_0040;
    cyc();
    check("lhs.restart", 64'(restart), 64'd1);
    check("lhs.rpc", 64'(restart_pc), 64'h8000_0040);
    check("lhs.mepc", 64'(mepc), 64'h8000_0100);
    check("lhs.mcause", 64'(mcause), 64'd4);
    check("lhs.we", 64'(rf_we), 64'd0);
    idle();
    cyc();
    cyc();
    retire(32'h8000_0040, 5'd5, 32'h0000_DEAD);
    cyc();
    check("rep.we", 64'(rf_we), 64'd1);
    check("rep.addr", 64'(rf_waddr), 64'd5);
    check("rep.data", 64'(rf_wdata), 64'h0000_DEAD);
    check("rep.minstret", minstret, 64'd5);

    // timer pending while interrupts disabled: retires
    retire(32'h8000_0060, 5'd6, 32'h66);
    me_timer_interrupt = 1'b1;
    cyc();
    check("tmr0.we", 64'(rf_we), 64'd1);
    check("tmr0.restart", 64'(restart), 64'd0);
    check("tmr0.minstret", minstret, 64'd6);
    idle();
    mie_set = 1'b1;
    cyc();
    retire(32'h8000_0080, 5'd8, 32'h88);
    me_timer_interrupt = 1'b1;
    cyc();
    check("irq.we", 64'(rf_we), 64'd0);
    check("irq.restart", 64'(restart), 64'd1);
    check("irq.rpc", 64'(restart_pc), 64'h8000_0010);
    check("irq.mcause", 64'(mcause), 64'h8000_0007);
    check("irq.mepc", 64'(mepc), 64'h8000_0080);
    check("irq.mtval", 64'(mtval), 64'd0);
    check("irq.minstret", minstret, 64'd6);
    idle();
    cyc();
    cyc();
    retire(32'h8000_0084, 5'd9, 32'h99);
    me_timer_interrupt = 1'b1;
    cyc();
    check("tmr1.we", 64'(rf_we), 64'd1);
    check("tmr1.restart", 64'(restart), 64'd0);
    check("tmr1.minstret", minstret, 64'd7);

    // misaligned store beats a pending interrupt
    idle();
    mie_set = 1'b1;
    cyc();
    retire(32'h8000_00A0, 5'd4, 32'h44);
    me_timer_interrupt = 1'b1;
    me_exc_misaligned  = 1'b1;
    me_exc_store       = 1'b1;
    me_exc_mtval       = 32'h8000_00A2;
    cyc();
    check("pri.mcause", 64'(mcause), 64'd6);
    check("pri.mepc", 64'(mepc), 64'h8000_00A0);
    check("pri.mtval", 64'(mtval), 64'h8000_00A2);
    check("pri.flushing", 64'(flushing), 64'd1);

    // asynchronous reset in the first flush cycle
    idle();
    #2;
    reset = 1'b0;
    #1;
    check_zero("rst1");
    reset = 1'b1;
    retire(32'h8000_0000, 5'd10, 32'h1234);
    cyc();
    check("post.we", 64'(rf_we), 64'd1);
    check("post.addr", 64'(rf_waddr), 64'd10);
    check("post.data", 64'(rf_wdata), 64'h1234);
    check("post.minstret", minstret, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
